// File: rtl/flexarray_pkg.sv
// Shared types for the flex-array operand path.
//   feeder_state_t : row feeder FSM encoding
//   DATA_W         : operand word width (matches the FIFO data port)
package flexarray_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SKEW   = 2'd1,
    STREAM = 2'd2
  } feeder_state_t;

endpackage : flexarray_pkg

// File: rtl/fifo_feeder.sv
// Row feeder between one operand FIFO and one systolic-array row input.
// On start it idles SKEW cycles (diagonal staggering across rows), then pops
// exactly K words and presents them on a registered valid/ready stream with
// last on word K. done pulses one cycle after the final beat is accepted.
//
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   start                begin one K-word transfer (sampled only in IDLE)
//   abort                synchronous cancel back to IDLE, no done
//   fifo_is_empty        upstream FIFO empty flag
//   fifo_dat_out [DW]    upstream FIFO head word
//   fifo_pop             combinational pop strobe to the FIFO
//   out_valid/out_ready  downstream handshake (out_valid registered)
//   out_data [DW]        registered output word
//   out_last             registered, marks word K
//   busy                 registered, high in SKEW and STREAM
//   done                 registered one-cycle completion pulse
module fifo_feeder
  import flexarray_pkg::*;
#(
  parameter int unsigned DW   = DATA_W,
  parameter int unsigned K    = 4,
  parameter int unsigned SKEW = 0
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          start,
  input  logic          abort,
  input  logic          fifo_is_empty,
  input  logic [DW-1:0] fifo_dat_out,
  output logic          fifo_pop,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  localparam int unsigned REM_W = $clog2(K + 1);
  localparam int unsigned SKW_W = (SKEW > 0) ? $clog2(SKEW + 1) : 1;

  localparam logic [REM_W-1:0] K_LOAD    = REM_W'(K);
  localparam logic [REM_W-1:0] REM_ONE   = REM_W'(1);
  localparam logic [SKW_W-1:0] SKEW_LOAD = SKW_W'((SKEW > 0) ? (SKEW - 1) : 0);

  // The parameter SKEW hides the imported state name, so the state is
  // always referenced through the package scope.
  feeder_state_t    state_q, state_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [SKW_W-1:0] skw_q, skw_d;
  logic             valid_d, last_d, done_d, busy_d;
  logic [DW-1:0]    data_d;
  logic             pop;
  logic             accept;

  assign accept   = out_valid && out_ready;
  assign fifo_pop = pop;

  // Next-state, counter and output-register logic
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    skw_d   = skw_q;
    valid_d = out_valid;
    last_d  = out_last;
    data_d  = out_data;
    done_d  = 1'b0;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          rem_d = K_LOAD;
          if (SKEW > 0) begin
            state_d = flexarray_pkg::SKEW;
            skw_d   = SKEW_LOAD;
          end else begin
            state_d = STREAM;
          end
        end
      end

      flexarray_pkg::SKEW: begin
        if (abort) begin
          state_d = IDLE;
        end else if (skw_q == '0) begin
          state_d = STREAM;
        end else begin
          skw_d = skw_q - 1'b1;
        end
      end

      STREAM: begin
        if (abort) begin
          // Drop the held word; unread FIFO words stay put.
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end else begin
          pop = (rem_q != '0) && !fifo_is_empty && (!out_valid || out_ready);
          if (pop) begin
            data_d  = fifo_dat_out;
            valid_d = 1'b1;
            last_d  = (rem_q == REM_ONE);
            rem_d   = rem_q - 1'b1;
          end else if (accept) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
          end
          // Once word K is out, rem_q is zero so no pop can coincide here.
          if (accept && out_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      skw_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      skw_q     <= skw_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_last  <= last_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

endmodule : fifo_feeder

// File: tb/tb_fifo_feeder.sv
// Bench for fifo_feeder: two instances (SKEW=0 and SKEW=3, K=4), each fed
// by a queue-based FIFO model; accepted beats are checked against a
// scoreboard filled when words are queued for the FIFO.
module tb_fifo_feeder;

  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  // Instance 0: SKEW=0
  logic          start, abort, out_ready;
  logic          fifo_is_empty = 1'b1;
  logic [DW-1:0] fifo_dat_out  = '0;
  logic          fifo_pop, out_valid, out_last, busy, done;
  logic [DW-1:0] out_data;

  // Instance 1: SKEW=3
  logic          start1, abort1, out_ready1;
  logic          fifo_is_empty1 = 1'b1;
  logic [DW-1:0] fifo_dat_out1  = '0;
  logic          fifo_pop1, out_valid1, out_last1, busy1, done1;
  logic [DW-1:0] out_data1;

  fifo_feeder #(.DW(DW), .K(4), .SKEW(0)) u_dut (
    .clk(clk), .nrst(nrst), .start(start), .abort(abort),
    .fifo_is_empty(fifo_is_empty), .fifo_dat_out(fifo_dat_out),
    .fifo_pop(fifo_pop), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  fifo_feeder #(.DW(DW), .K(4), .SKEW(3)) u_dut_skew (
    .clk(clk), .nrst(nrst), .start(start1), .abort(abort1),
    .fifo_is_empty(fifo_is_empty1), .fifo_dat_out(fifo_dat_out1),
    .fifo_pop(fifo_pop1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_last(out_last1), .busy(busy1), .done(done1)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // FIFO models: pending pushes land at the next clock edge
  logic [DW-1:0] fq[$];
  logic [DW-1:0] push_q[$];
  logic [DW-1:0] late_q[$];
  logic [DW-1:0] fq1[$];

  always @(posedge clk) begin
    if (fifo_pop) begin
      if (fq.size() == 0) chk("pop_on_empty", 32'(1), 32'(0));
      else void'(fq.pop_front());
    end
    while (push_q.size() > 0) fq.push_back(push_q.pop_front());
    fifo_is_empty <= (fq.size() == 0);
    fifo_dat_out  <= (fq.size() > 0) ? fq[0] : '0;
  end

  always @(posedge clk) begin
    if (fifo_pop1) begin
      if (fq1.size() == 0) chk("pop1_on_empty", 32'(1), 32'(0));
      else void'(fq1.pop_front());
    end
    fifo_is_empty1 <= (fq1.size() == 0);
    fifo_dat_out1  <= (fq1.size() > 0) ? fq1[0] : '0;
  end

  // Scoreboards: {last, data}
  logic [DW:0] exp_q[$];
  logic [DW:0] exp1_q[$];

  task automatic exp_put(input logic [DW-1:0] w, input logic last);
    exp_q.push_back({last, w});
  endtask

  // Monitors sample mid-low-phase, after the negedge drives have settled
  always begin
    logic [DW:0] e;
    @(negedge clk);
    #2;
    if (nrst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb_extra_beat", out_data, 32'hDEAD_BEEF);
      else begin
        e = exp_q.pop_front();
        chk("sb_data", out_data, e[DW-1:0]);
        chk("sb_last", 32'(out_last), 32'(e[DW]));
      end
    end
  end

  always begin
    logic [DW:0] e;
    @(negedge clk);
    #2;
    if (nrst && out_valid1 && out_ready1) begin
      if (exp1_q.size() == 0) chk("sb1_extra_beat", out_data1, 32'hDEAD_BEEF);
      else begin
        e = exp1_q.pop_front();
        chk("sb1_data", out_data1, e[DW-1:0]);
        chk("sb1_last", 32'(out_last1), 32'(e[DW]));
      end
    end
  end

  // One transfer on instance 0: start in cycle 0, optional stall window,
  // abort cycle and late-push cycle; per-cycle activity bitmaps returned.
  task automatic run(input int ncyc, input int stall_lo, input int stall_hi,
                     input int abort_at, input int push_at, input logic [DW-1:0] hold_w,
                     output logic [15:0] pop_v, output logic [15:0] valid_v,
                     output logic [15:0] done_v, output logic [15:0] busy_v);
    pop_v = '0; valid_v = '0; done_v = '0; busy_v = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      start     = (c == 0);
      abort     = (c == abort_at);
      out_ready = !(c >= stall_lo && c < stall_hi);
      if (c == push_at) while (late_q.size() > 0) push_q.push_back(late_q.pop_front());
      #2;
      pop_v[c]   = fifo_pop;
      valid_v[c] = out_valid;
      done_v[c]  = done;
      busy_v[c]  = busy;
      if (!out_ready && out_valid) begin
        chk("bp_hold_data", out_data, hold_w);
        chk("bp_no_pop", 32'(fifo_pop), 32'(0));
      end
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; out_ready = 1'b1;
  endtask

  logic [15:0] pv, vv, dv, bv;

  initial begin
    nrst = 1'b0;
    start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; out_ready1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fq1.push_back(32'hA0 + 32'(i));
      exp1_q.push_back({(i == 3), 32'hA0 + 32'(i)});
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_data",  out_data, 32'(0));
    chk("rst_last",  32'(out_last), 32'(0));
    chk("rst_done",  32'(done), 32'(0));
    chk("rst_busy",  32'(busy), 32'(0));
    chk("rst_pop",   32'(fifo_pop), 32'(0));
    nrst = 1'b1;
    @(negedge clk);

    // Skew-free streaming
    for (int i = 0; i < 4; i++) begin
      push_q.push_back(32'hA0 + 32'(i));
      exp_put(32'hA0 + 32'(i), (i == 3));
    end
    run(10, 0, 0, -1, -1, '0, pv, vv, dv, bv);
    chk("s0_pop_map",   32'(pv), 32'h1E);
    chk("s0_valid_map", 32'(vv), 32'h3C);
    chk("s0_done_map",  32'(dv), 32'h40);
    chk("s0_busy_map",  32'(bv), 32'h3E);

    // Skew delay on the SKEW=3 instance
    pv = '0; vv = '0; dv = '0; bv = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      start1 = (c == 0);
      #2;
      pv[c] = fifo_pop1; vv[c] = out_valid1; dv[c] = done1; bv[c] = busy1;
    end
    start1 = 1'b0;
    chk("skew_pop_map",   32'(pv), 32'hF0);
    chk("skew_valid_map", 32'(vv), 32'h1E0);
    chk("skew_done_map",  32'(dv), 32'h200);
    chk("skew_busy_map",  32'(bv), 32'h1FE);

    // Backpressure right after the first valid
    for (int i = 0; i < 4; i++) begin
      push_q.push_back(32'hB0 + 32'(i));
      exp_put(32'hB0 + 32'(i), (i == 3));
    end
    @(negedge clk);
    run(12, 2, 5, -1, -1, 32'hB0, pv, vv, dv, bv);
    chk("bp_pop_map",   32'(pv), 32'hE2);
    chk("bp_valid_map", 32'(vv), 32'h1FC);
    chk("bp_done_map",  32'(dv), 32'h200);

    // Empty FIFO mid-vector, refilled later
    for (int i = 0; i < 4; i++) begin
      if (i < 2) push_q.push_back(32'hC0 + 32'(i));
      else       late_q.push_back(32'hC0 + 32'(i));
      exp_put(32'hC0 + 32'(i), (i == 3));
    end
    @(negedge clk);
    run(12, 0, 0, -1, 5, '0, pv, vv, dv, bv);
    chk("empty_pop_map",   32'(pv), 32'hC6);
    chk("empty_valid_map", 32'(vv), 32'h18C);
    chk("empty_done_map",  32'(dv), 32'h200);
    chk("empty_busy_map",  32'(bv), 32'h1FE);

    // Abort in the cycle of the second accepted beat
    for (int i = 0; i < 4; i++) push_q.push_back(32'hD0 + 32'(i));
    exp_put(32'hD0, 1'b0);
    exp_put(32'hD1, 1'b0);
    @(negedge clk);
    run(8, 0, 0, 3, -1, '0, pv, vv, dv, bv);
    chk("abort_pop_map",   32'(pv), 32'h06);
    chk("abort_valid_map", 32'(vv), 32'h0C);
    chk("abort_done_map",  32'(dv), 32'h00);
    chk("abort_busy_map",  32'(bv), 32'h0E);
    chk("abort_fifo_left", 32'(fq.size()), 32'(2));

    // Restart: leftover words become words 1-2 of the new vector
    exp_put(32'hD2, 1'b0);
    exp_put(32'hD3, 1'b0);
    late_q.push_back(32'hE0);
    late_q.push_back(32'hE1);
    exp_put(32'hE0, 1'b0);
    exp_put(32'hE1, 1'b1);
    run(10, 0, 0, -1, 0, '0, pv, vv, dv, bv);
    chk("restart_pop_map",  32'(pv), 32'h1E);
    chk("restart_done_map", 32'(dv), 32'h40);
    chk("restart_fifo_left", 32'(fq.size()), 32'(0));

    // Reset while a word is held
    for (int i = 0; i < 4; i++) push_q.push_back(32'hF0 + 32'(i));
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    chk("mid_valid_before_rst", 32'(out_valid), 32'(1));
    #1;
    nrst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_data",  out_data, 32'(0));
    chk("mid_rst_last",  32'(out_last), 32'(0));
    chk("mid_rst_busy",  32'(busy), 32'(0));
    chk("mid_rst_pop",   32'(fifo_pop), 32'(0));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2;
    chk("mid_rst_start_ignored", 32'(busy), 32'(0));
    fq.delete();
    nrst = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    chk("post_rst_busy",  32'(busy), 32'(0));
    chk("post_rst_valid", 32'(out_valid), 32'(0));

    chk("sb_leftover",  32'(exp_q.size()), 32'(0));
    chk("sb1_leftover", 32'(exp1_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_fifo_feeder
